// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU control codes and sequencer state encodings shared by alu_seq_unit and alu_op_decode.
package alu_seq_pkg;
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLT    = 4'b0101;
  localparam logic [3:0] ALU_SLTU   = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_MUL    = 4'b1010;
  localparam logic [3:0] ALU_MULH   = 4'b1011;
  localparam logic [3:0] ALU_MULHSU = 4'b1100;
  localparam logic [3:0] ALU_MULHU  = 4'b1101;
  // Divide codes: bit 0 selects unsigned; quotient/remainder comes from the decoder's variant bit.
  localparam logic [3:0] ALU_DIV    = 4'b1110;
  localparam logic [3:0] ALU_DIVU   = 4'b1111;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } alu_state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU_op/funct3/funct7 decode to control code plus mul/div/illegal flags.
// Div/rem decode only when ALU_DIV_EN is defined; otherwise they report illegal.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        i_alu_op,
  input  logic [2:0]        i_funct3,
  input  logic              i_funct7b5,
  input  logic              i_funct7b0,
  input  logic              i_opcode_b5,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_is_mul,
  output logic              o_is_div,
  output logic              o_is_rem,
  output logic              o_illegal
);
  logic       w_mop;
  logic [3:0] w_base;
  logic [3:0] w_br;
  logic [3:0] w_mcode;
  always_comb begin
    w_mop = i_alu_op[1] & i_opcode_b5 & i_funct7b0;
    w_br = i_funct3[2:1] == 2'b00 ? ALU_SUB : i_funct3[2:1] == 2'b10 ? ALU_SLT : ALU_SLTU;
    w_base = ALU_AND;
    case (i_funct3)
      3'b000: w_base = (i_funct7b5 & i_opcode_b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_base = ALU_SLL;
      3'b010: w_base = ALU_SLT;
      3'b011: w_base = ALU_SLTU;
      3'b100: w_base = ALU_XOR;
      3'b101: w_base = i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: w_base = ALU_OR;
      default: w_base = ALU_AND;
    endcase
    w_mcode = i_funct3[2] ? {3'b111, i_funct3[0]} : ALU_MUL + {2'b00, i_funct3[1:0]};
    o_is_mul = w_mop & ~i_funct3[2];
`ifdef ALU_DIV_EN
    o_is_div = w_mop & i_funct3[2];
`else
    o_is_div = 1'b0;
`endif
    o_is_rem = i_funct3[1];
    o_illegal = (i_alu_op == 2'b01 && i_funct3[2:1] == 2'b01) | (w_mop & i_funct3[2] & ~o_is_div);
    o_ctrl = CTRL_W'(i_alu_op == 2'b00 ? ALU_ADD : i_alu_op == 2'b01 ? w_br : w_mop ? w_mcode : w_base);
  end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered base ALU with iterative RV32M multiply and (with ALU_DIV_EN) restoring divide.
// Valid/ready on both sides; operands and decoded op are captured at acceptance.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALU_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            opcode_b5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);
  alu_state_t          r_state;
  logic                r_in_ready, r_out_valid, r_zero, r_illegal, r_neg, r_sel;
  logic [XLEN-1:0]     r_result, r_op;
  logic [2*XLEN-1:0]   r_acc;
  logic [SHW-1:0]      r_cnt;
  logic [CTRL_W-1:0]   w_ctrl;
  logic [3:0]          w_op;
  logic                w_is_mul, w_is_div, w_is_rem, w_illegal;
  logic                w_accept, w_as, w_bs, w_fast, w_finish;
  logic [SHW-1:0]      w_sh;
  logic [XLEN-1:0]     w_base, w_first, w_fin, w_ma, w_mb, w_mres;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod, w_pfix;
`ifdef ALU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic                r_nrem;
  logic                w_ge;
  logic [XLEN:0]       w_top;
  logic [2*XLEN-1:0]   w_div_next;
  logic [XLEN-1:0]     w_fast_res, w_q, w_r, w_dres;
`endif

  alu_op_decode #(.CTRL_W(CTRL_W)) u_dec (
    .i_alu_op   (ALU_op),
    .i_funct3   (funct3),
    .i_funct7b5 (funct7b5),
    .i_funct7b0 (funct7b0),
    .i_opcode_b5(opcode_b5),
    .o_ctrl     (w_ctrl),
    .o_is_mul   (w_is_mul),
    .o_is_div   (w_is_div),
    .o_is_rem   (w_is_rem),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_op = w_ctrl[3:0];
    w_accept = in_valid & r_in_ready;
    w_sh = b[SHW-1:0];
    w_base = '0;
    case (w_op)
      ALU_ADD:  w_base = a + b;
      ALU_SUB:  w_base = a - b;
      ALU_AND:  w_base = a & b;
      ALU_OR:   w_base = a | b;
      ALU_XOR:  w_base = a ^ b;
      ALU_SLT:  w_base = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: w_base = XLEN'(a < b);
      ALU_SLL:  w_base = a << w_sh;
      ALU_SRL:  w_base = a >> w_sh;
      ALU_SRA:  w_base = $signed(a) >>> w_sh;
      default:  w_base = '0;
    endcase
    w_as = w_is_mul ? (w_op == ALU_MULH || w_op == ALU_MULHSU) : ~w_op[0];
    w_bs = w_is_mul ? w_op == ALU_MULH : ~w_op[0];
    w_ma = (w_as & a[XLEN-1]) ? -a : a;
    w_mb = (w_bs & b[XLEN-1]) ? -b : b;
    // Shift-add: high half accumulates the multiplicand, low half drains the multiplier.
    w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
    w_prod = {w_sum, r_acc[XLEN-1:1]};
    w_pfix = r_neg ? -w_prod : w_prod;
    w_mres = r_sel ? w_pfix[2*XLEN-1:XLEN] : w_pfix[XLEN-1:0];
`ifdef ALU_DIV_EN
    // Restoring step on {remainder, quotient}; r_op holds the divisor magnitude.
    w_top = r_acc[2*XLEN-1:XLEN-1];
    w_ge = w_top >= {1'b0, r_op};
    w_div_next = {w_ge ? w_top[XLEN-1:0] - r_op : w_top[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
    w_q = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_r = r_nrem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_dres = r_sel ? w_r : w_q;
    w_fast = w_is_div & (b == '0 || (~w_op[0] && a == MIN_NEG && b == '1));
    w_fast_res = b == '0 ? (w_is_rem ? a : '1) : (w_is_rem ? '0 : a);
    w_first = w_illegal ? '0 : w_fast ? w_fast_res : w_base;
    w_fin = r_state == S_IDLE ? w_first : r_state == S_MUL ? w_mres : w_dres;
`else
    w_fast = 1'b0;
    w_first = w_illegal ? '0 : w_base;
    w_fin = r_state == S_IDLE ? w_first : w_mres;
`endif
    w_finish = (r_state == S_IDLE && w_accept && (~(w_is_mul | w_is_div) | w_illegal | w_fast))
             | (r_state == S_MUL && r_cnt == '0) | (r_state == S_SIGN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_result <= '0;
      r_zero <= 1'b0;
      r_illegal <= 1'b0;
      r_acc <= '0;
      r_op <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_sel <= 1'b0;
`ifdef ALU_DIV_EN
      r_nrem <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_acc <= {{XLEN{1'b0}}, w_is_mul ? w_mb : w_ma};
          r_op <= w_is_mul ? w_ma : w_mb;
          r_neg <= (w_as & a[XLEN-1]) ^ (w_bs & b[XLEN-1]);
          r_sel <= w_is_mul ? w_op != ALU_MUL : w_is_rem;
`ifdef ALU_DIV_EN
          r_nrem <= w_as & a[XLEN-1];
`endif
          r_cnt <= SHW'(XLEN - 1);
          r_in_ready <= 1'b0;
          r_state <= w_is_mul ? S_MUL : S_DIV;
        end
        S_MUL: begin
          r_acc <= w_prod;
          r_cnt <= r_cnt - 1'b1;
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_SIGN;
        end
`endif
        S_DONE: if (out_ready) begin
          r_state <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
      if (w_finish) begin
        r_state <= S_DONE;
        r_out_valid <= 1'b1;
        r_result <= w_fin;
        r_zero <= w_fin == '0;
        r_illegal <= r_state == S_IDLE && w_illegal;
      end
    end
  end

  assign in_ready = r_in_ready;
  assign out_valid = r_out_valid;
  assign result = r_result;
  assign zero = r_zero;
  assign illegal = r_illegal;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vectors with a scoreboard queue; a negedge monitor checks result, flags and latency.
module tb_alu_seq_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ALU_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        funct7b0 = 1'b0;
  logic        opcode_b5 = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic        ill;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        prev_v = 1'b0;
  logic [31:0] held = '0;

  alu_seq_unit #(.XLEN(32), .CTRL_W(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALU_op   (ALU_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .funct7b0 (funct7b0),
    .opcode_b5(opcode_b5),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, ".result"}, result, e.res);
        chk({e.nm, ".illegal"}, {31'b0, illegal}, {31'b0, e.ill});
        chk({e.nm, ".zero"}, {31'b0, zero}, {31'b0, e.res == 32'h0});
        chk({e.nm, ".cycle"}, cyc, e.at);
      end
      held = result;
    end else if (reset_n && out_valid && prev_v) begin
      chk("hold.result", result, held);
      chk("hold.in_ready", {31'b0, in_ready}, 32'h0);
    end
    prev_v = out_valid;
  end

  task automatic issue(input string nm, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7b5, input logic f7b0, input logic opb5,
                       input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] er, input logic eill, input int lat, input bit push);
    int w;
    exp_t e;
    w = 0;
    @(negedge clock);
    ALU_op = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opcode_b5 = opb5;
    a = ia; b = ib; in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s.accept: got in_ready=0 expected 1 within 200 cycles", nm);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    if (push) begin
      e.nm = nm; e.res = er; e.ill = eill; e.at = cyc + lat - 1;
      sb.push_back(e);
    end
    @(negedge clock);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; funct3 = 3'($urandom); ALU_op = 2'($urandom);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    chk({nm, ".drained"}, sb.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset.in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset.out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset.result", result, 32'h0);
    chk("reset.flags", {30'b0, zero, illegal}, 32'h0);
    reset_n = 1'b1;

    issue("sub",   2'b10, 3'b000, 1, 0, 1, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 1, 1);
    issue("sra",   2'b10, 3'b101, 1, 0, 1, 32'h80000000, 32'd4, 32'hF8000000, 0, 1, 1);
    issue("srl",   2'b10, 3'b101, 0, 0, 1, 32'h80000000, 32'd4, 32'h08000000, 0, 1, 1);
    issue("addi",  2'b10, 3'b000, 1, 0, 0, 32'd5, 32'd7, 32'd12, 0, 1, 1);
    issue("add0",  2'b00, 3'b111, 1, 1, 1, 32'hFFFFFFFF, 32'd1, 32'h0, 0, 1, 1);
    issue("beq",   2'b01, 3'b000, 0, 0, 0, 32'd3, 32'd3, 32'h0, 0, 1, 1);
    issue("blt",   2'b01, 3'b100, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 1, 1);
    issue("bltu",  2'b01, 3'b110, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 1);
    issue("brill", 2'b01, 3'b010, 0, 0, 0, 32'd9, 32'd4, 32'd0, 1, 1, 1);
    issue("and",   2'b10, 3'b111, 0, 0, 1, 32'hF0F0, 32'hFF00, 32'hF000, 0, 1, 1);
    issue("or",    2'b10, 3'b110, 0, 0, 1, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 1, 1);
    issue("xor",   2'b10, 3'b100, 0, 0, 1, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 1, 1);
    issue("sll",   2'b10, 3'b001, 0, 0, 1, 32'd1, 32'h21, 32'd2, 0, 1, 1);
    issue("slt",   2'b11, 3'b010, 0, 0, 1, 32'h80000000, 32'd0, 32'd1, 0, 1, 1);
    issue("sltu",  2'b10, 3'b011, 0, 0, 1, 32'h80000000, 32'd0, 32'd0, 0, 1, 1);

    issue("mulh",  2'b10, 3'b001, 0, 1, 1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, 33, 1);
    begin
      bit seen_ready;
      int w;
      seen_ready = 0;
      w = 0;
      while (!out_valid && w < 60) begin
        if (in_ready) seen_ready = 1;
        @(negedge clock);
        w++;
      end
      chk("mulh.busy_in_ready", {31'b0, seen_ready}, 32'h0);
    end
    issue("mul",    2'b10, 3'b000, 0, 1, 1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 0, 33, 1);
    issue("mulhu",  2'b10, 3'b011, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33, 1);
    issue("mulhsu", 2'b10, 3'b010, 0, 1, 1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, 33, 1);

`ifdef ALU_DIV_EN
    issue("div_ovf", 2'b10, 3'b100, 0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 1);
    issue("divu0",   2'b10, 3'b101, 0, 1, 1, 32'd77, 32'd0, 32'hFFFFFFFF, 0, 1, 1);
    issue("rem0",    2'b10, 3'b110, 0, 1, 1, 32'h1234, 32'd0, 32'h1234, 0, 1, 1);
    issue("rem",     2'b10, 3'b110, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 34, 1);
    issue("div",     2'b10, 3'b100, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 34, 1);
    issue("divu",    2'b10, 3'b101, 0, 1, 1, 32'd100, 32'd7, 32'd14, 0, 34, 1);
    issue("remu",    2'b10, 3'b111, 0, 1, 1, 32'd100, 32'd7, 32'd2, 0, 34, 1);
`else
    issue("div_ovf", 2'b10, 3'b100, 0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 1, 1);
    issue("divu0",   2'b10, 3'b101, 0, 1, 1, 32'd77, 32'd0, 32'h0, 1, 1, 1);
    issue("rem",     2'b10, 3'b110, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 32'h0, 1, 1, 1);
    issue("remu",    2'b10, 3'b111, 0, 1, 1, 32'd100, 32'd7, 32'h0, 1, 1, 1);
`endif
    drain("ops");

    out_ready = 1'b0;
    issue("hold", 2'b10, 3'b100, 0, 0, 1, 32'hA5, 32'h0F, 32'hAA, 0, 1, 1);
    repeat (5) @(negedge clock);
    chk("hold.out_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("after_done.out_valid", {31'b0, out_valid}, 32'h0);
    chk("after_done.result", result, 32'hAA);
    chk("after_done.in_ready", {31'b0, in_ready}, 32'h1);
    drain("hold");

    issue("mul_rst", 2'b10, 3'b001, 0, 1, 1, 32'h12345, 32'h6789, 32'h0, 0, 33, 0);
    repeat (9) @(negedge clock);
    chk("rst_mid.busy", {31'b0, in_ready}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_rel.in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_rel.result", result, 32'h0);
    repeat (40) @(negedge clock);
    chk("rst_rel.no_stale_valid", {31'b0, out_valid}, 32'h0);
    issue("post_rst", 2'b00, 3'b000, 0, 0, 0, 32'd1, 32'd2, 32'd3, 0, 1, 1);
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, multi-cycle successor to the CPU's combinational ALU control path: decodes ALU_op/funct3/funct7 into an internal 4-bit operation code, executes base integer ops in one registered cycle, and executes RV32M multiply/divide iteratively. Sits in the execute stage between the register file and writeback. A valid/ready handshake on both sides lets the core stall on multi-cycle operations.

## Interface
- XLEN, 32: operand/result width; must be a power of 2 and at least 8.
- CTRL_W, 4: internal ALU control code width.

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; reset 1
- ALU_op  in  2  00 add, 01 branch compare, 1x R/I-type decode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- funct7b0  in  1  instruction bit 25 (M-extension select)
- opcode_b5  in  1  1 = R-type
- a, b  in  XLEN  operands
- out_valid  out  1  result available; reset 0
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result; reset 0
- zero  out  1  result == 0; reset 0
- illegal  out  1  undecodable op, qualified by out_valid; reset 0

## Operation
- Decode when ALU_op=00: add. When ALU_op=01: funct3 000/001 → sub; 100/101 → slt; 110/111 → sltu; 010/011 → illegal.
- Decode when ALU_op=1x and not M-op: funct3 000 → add, or sub when funct7b5&opcode_b5; 001 → sll; 010 → slt; 011 → sltu; 100 → xor; 101 → srl, or sra when funct7b5; 110 → or; 111 → and.
- M-op = ALU_op[1] & opcode_b5 & funct7b0. funct3 0-3 are mul/mulh/mulhsu/mulhu; 4-7 are div/divu/rem/remu.
- Shift amount = b[log2(XLEN)-1:0]. Arithmetic wraps modulo 2^XLEN.
- An illegal op completes like a base op, with result 0 and illegal=1. No x values on any output.
- FSM states:
  - IDLE: in_ready=1.
  - MUL: XLEN iterations; shift-add on magnitudes, 2·XLEN-bit accumulator, sign fix in the last iteration.
  - DIV: XLEN restoring iterations, then one SIGN cycle.
  - DONE: out_valid=1.
- Transitions: IDLE→DONE for base/illegal/div special cases; IDLE→MUL; IDLE→DIV; DIV→SIGN→DONE; DONE→IDLE when out_ready.
- Operands and decoded op are latched at acceptance, so inputs may change after the handshake.
- Div special cases take the fast path (IDLE→DONE):
  - b=0: quotient all-ones, remainder = a.
  - Signed a = −2^(XLEN−1) with b = −1: quotient = a, remainder = 0.

## Timing
- Handshake accepted on an edge where in_valid & in_ready. in_ready=0 in every state except IDLE.
- Base/illegal/fast-path latency: out_valid at acceptance edge +1.
- MUL latency: out_valid at acceptance +XLEN+1.
- DIV latency: out_valid at acceptance +XLEN+2.
- result, zero, illegal are stable while out_valid=1 and out_ready=0. They hold their last value after DONE→IDLE.
- No back-to-back acceptance in DONE; minimum issue interval is 2 cycles.
- reset_n low mid-operation: immediately go to IDLE, out_valid=0, accumulators cleared, in_ready=1 on release.

## Configuration
- ALU_DIV_EN defined: DIV and SIGN states and the divider datapath are present.
- ALU_DIV_EN undefined: no divider hardware. Div/rem funct3 4-7 decode as illegal (1-cycle, result 0, illegal=1); mul is unaffected.

## Structure
- Package alu_seq_pkg holds:
  - ALU control code localparams (ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001, MUL*=1010-1101, DIV*=1110-1111 plus an op-variant bit).
  - FSM state encodings.
- Sub-module alu_op_decode: purely combinational decode of ALU_op/funct3/funct7b5/funct7b0/opcode_b5 to {ctrl, is_mul, is_div, illegal}; reused by the single-cycle core.

## Test plan
- ALU_op=10, opcode_b5=1, funct7b5=1, funct3=000, a=5, b=7 → out_valid at +1, result=0xFFFFFFFE, zero=0.
- funct3=101, funct7b5=1, a=0x80000000, b=4 → result=0xF8000000; same with funct7b5=0 → 0x08000000.
- mulh (funct7b0=1, funct3=001), a=0xFFFFFFFF, b=2 → result=0xFFFFFFFF at +33; in_ready=0 throughout.
- div, a=0x80000000, b=0xFFFFFFFF → result=0x80000000 at +1. divu with b=0 → 0xFFFFFFFF; rem a=−7, b=2 → 0xFFFFFFFF at +34.
- Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Assert reset_n=0 during MUL iteration 10 → out_valid=0 immediately, in_ready=1 after release.
- Without ALU_DIV_EN: div → illegal=1, result=0 at +1. ALU_op=01 with funct3=010 → illegal=1.
